// File: rtl/lpc_pkg.sv
// lpc_pkg: shared state type and LAD codes for the LPC I/O target.
// SYNC wait insertion is selected by LPC_SYNC_WAIT_EN in lpc_io_target.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SWAIT,
    ST_SYNC,
    ST_RDATA,
    ST_TTAR
  } lpc_state_e;

  localparam logic [3:0] LPC_START       = 4'h0;
  localparam logic [3:0] IO_RD           = 4'h0;
  localparam logic [3:0] IO_WR           = 4'h2;
  localparam logic [3:0] SYNC_READY      = 4'h0;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;
  localparam logic [3:0] LAD_TAR         = 4'hF;

endpackage

// File: rtl/lpc_io_target_if.sv
// lpc_io_target_if: LPC frame/LAD pad bundle between host and target.
// master = host side, slave = I/O target side.
interface lpc_io_target_if;

  logic       LFRAMEn;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;

  modport master (
    output LFRAMEn,
    output LadIn,
    input  LadOut,
    input  LadOe
  );

  modport slave (
    input  LFRAMEn,
    input  LadIn,
    output LadOut,
    output LadOe
  );

endinterface

// File: rtl/lpc_nibble_shift.sv
// lpc_nibble_shift: 16-bit address (MSB nibble first) and 8-bit data
// (LSB nibble first) shifters, with a parallel load for read data.
module lpc_nibble_shift
  import lpc_pkg::*;
(
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        i_addr_shift,
  input  logic        i_data_shift,
  input  logic        i_data_load,
  input  logic [3:0]  i_nib,
  input  logic [7:0]  i_load,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data
);

  logic [15:0] r_addr;
  logic [7:0]  r_data;

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (i_addr_shift)
        r_addr <= {r_addr[11:0], i_nib};
      unique case (1'b1)
        i_data_load:  r_data <= i_load;
        i_data_shift: r_data <= {i_nib, r_data[7:4]};
        default:      r_data <= r_data;
      endcase
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC I/O-cycle target decoding a 32-byte window into
// register strobes. Define LPC_SYNC_WAIT_EN to add one short-wait SYNC.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic             LpcClock,
  input  logic             PciReset,
  lpc_io_target_if.slave   bus,
  input  logic [7:0]       ReadData,
  output logic             Write,
  output logic             Read,
  output logic [4:0]       RegAddress,
  output logic [7:0]       Data
);

  localparam logic [15:0] WIN_MASK = 16'hFFE0;

`ifdef LPC_SYNC_WAIT_EN
  localparam lpc_state_e STROBE_ST = ST_SWAIT;
`else
  localparam lpc_state_e STROBE_ST = ST_SYNC;
`endif

  lpc_state_e  r_st;
  logic [1:0]  r_cnt;
  logic        r_wr;
  lpc_state_e  w_nst;
  logic [1:0]  w_ncnt;
  logic [15:0] w_addr;
  logic [15:0] w_addr_nx;
  logic [7:0]  w_data;
  logic        w_hit;
  logic        w_load;
  logic        w_ashift;
  logic        w_dshift;

  // Decode sees the address as it will be after the last nibble lands.
  assign w_addr_nx = (w_addr << 4) | {12'h000, bus.LadIn};
  assign w_hit     = (w_addr_nx & WIN_MASK) == (BASE_ADDR & WIN_MASK);
  assign w_ashift  = bus.LFRAMEn && (r_st == ST_ADDR);
  assign w_dshift  = bus.LFRAMEn && (r_st == ST_WDATA);
  assign w_load    = (r_st == STROBE_ST) && !r_wr;

  lpc_nibble_shift u_shift (
    .LpcClock     (LpcClock),
    .PciReset     (PciReset),
    .i_addr_shift (w_ashift),
    .i_data_shift (w_dshift),
    .i_data_load  (w_load),
    .i_nib        (bus.LadIn),
    .i_load       (ReadData),
    .o_addr       (w_addr),
    .o_data       (w_data)
  );

  assign RegAddress = w_addr[4:0];
  assign Data       = w_data;

  always_comb begin
    w_nst  = r_st;
    w_ncnt = r_cnt + 2'd1;
    if (!bus.LFRAMEn) begin
      w_ncnt = '0;
      w_nst  = (bus.LadIn == LPC_START) ? ST_CYCTYPE : ST_IDLE;
    end else begin
      unique case (r_st)
        ST_IDLE: w_ncnt = '0;
        ST_CYCTYPE: begin
          w_ncnt = '0;
          w_nst  = (bus.LadIn == IO_RD || bus.LadIn == IO_WR) ?
                   ST_ADDR : ST_IDLE;
        end
        ST_ADDR: if (r_cnt == 2'd3) begin
          w_ncnt = '0;
          w_nst  = !w_hit ? ST_IDLE : r_wr ? ST_WDATA : ST_HTAR;
        end
        ST_WDATA: if (r_cnt[0]) begin
          w_ncnt = '0;
          w_nst  = ST_HTAR;
        end
        ST_HTAR: if (r_cnt[0]) begin
          w_ncnt = '0;
          w_nst  = STROBE_ST;
        end
        ST_SWAIT: begin
          w_ncnt = '0;
          w_nst  = ST_SYNC;
        end
        ST_SYNC: begin
          w_ncnt = '0;
          w_nst  = r_wr ? ST_TTAR : ST_RDATA;
        end
        ST_RDATA: if (r_cnt[0]) begin
          w_ncnt = '0;
          w_nst  = ST_TTAR;
        end
        ST_TTAR: if (r_cnt[0]) begin
          w_ncnt = '0;
          w_nst  = ST_IDLE;
        end
        default: begin
          w_ncnt = '0;
          w_nst  = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_st       <= ST_IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      Write      <= 1'b0;
      Read       <= 1'b0;
      bus.LadOe  <= 1'b0;
      bus.LadOut <= LAD_TAR;
    end else begin
      r_st  <= w_nst;
      r_cnt <= w_ncnt;
      if (r_st == ST_CYCTYPE && bus.LFRAMEn)
        r_wr <= (bus.LadIn == IO_WR);
      Write <= (w_nst == STROBE_ST) && r_wr;
      Read  <= (w_nst == STROBE_ST) && !r_wr;
      // Pad drive reflects the bus cycle being entered.
      unique case (w_nst)
        ST_SWAIT: begin
          bus.LadOe  <= 1'b1;
          bus.LadOut <= SYNC_SHORT_WAIT;
        end
        ST_SYNC: begin
          bus.LadOe  <= 1'b1;
          bus.LadOut <= SYNC_READY;
        end
        ST_RDATA: begin
          bus.LadOe  <= 1'b1;
          bus.LadOut <= w_ncnt[0] ? w_data[7:4] :
                        w_load ? ReadData[3:0] : w_data[3:0];
        end
        ST_TTAR: begin
          bus.LadOe  <= !w_ncnt[0];
          bus.LadOut <= LAD_TAR;
        end
        default: begin
          bus.LadOe  <= 1'b0;
          bus.LadOut <= LAD_TAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// tb_lpc_io_target: directed LPC host stimulus with an event scoreboard
// checked by a negedge monitor against hand-derived expectations.
module tb_lpc_io_target;
  import lpc_pkg::*;

`ifdef LPC_SYNC_WAIT_EN
  localparam int SW = 1;
`else
  localparam int SW = 0;
`endif

  typedef struct {
    int         cyc;
    logic       w;
    logic       r;
    logic [3:0] lad;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       PciReset;
  logic [7:0] ReadData;
  logic       Write;
  logic       Read;
  logic [4:0] RegAddress;
  logic [7:0] Data;

  lpc_io_target_if bus();

  lpc_io_target #(.BASE_ADDR(16'h0800)) dut (
    .LpcClock   (clk),
    .PciReset   (PciReset),
    .bus        (bus),
    .ReadData   (ReadData),
    .Write      (Write),
    .Read       (Read),
    .RegAddress (RegAddress),
    .Data       (Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file with read-to-clear behaviour.
  logic [31:0] cleared = '0;
  always @(posedge clk) if (Read) cleared[RegAddress] <= 1'b1;

  function automatic logic [7:0] rom(input logic [4:0] a);
    case (a)
      5'd3:    return 8'hA5;
      5'd5:    return 8'h3C;
      default: return {3'b000, a};
    endcase
  endfunction

  always_comb ReadData = cleared[RegAddress] ? 8'h00 : rom(RegAddress);

  ev_t q[$];
  int  rd = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  rc_req = 0;
  int  rc_ack = 0;
  bit  fin_req = 0;
  bit  fin_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  obs;
    bit  due;
    bit  ok;
    if (rc_req != rc_ack) begin
      chk("rst_LadOe", 32'(bus.LadOe), 32'h0);
      chk("rst_LadOut", 32'(bus.LadOut), 32'hF);
      chk("rst_Write", 32'(Write), 32'h0);
      chk("rst_Read", 32'(Read), 32'h0);
      chk("rst_RegAddress", 32'(RegAddress), 32'h0);
      chk("rst_Data", 32'(Data), 32'h0);
      rc_ack = rc_req;
    end
    obs = Write || Read || bus.LadOe;
    due = (rd < q.size()) && (q[rd].cyc == cyc);
    if (obs || due) begin
      n_chk++;
      if (!due) begin
        $display("FAIL sb_unexpected: got W=%b R=%b oe=%b lad=%h want idle (cyc %0d)",
                 Write, Read, bus.LadOe, bus.LadOut, cyc);
      end else begin
        e  = q[rd];
        rd = rd + 1;
        ok = (Write === e.w) && (Read === e.r) && (bus.LadOe === 1'b1) &&
             (bus.LadOut === e.lad) &&
             (!(e.w || e.r) || RegAddress === e.addr) &&
             (!e.w || Data === e.data);
        if (ok) n_pass++;
        else $display("FAIL sb_cyc%0d: got W=%b R=%b oe=%b lad=%h a=%h d=%h want W=%b R=%b oe=1 lad=%h a=%h d=%h",
                      cyc, Write, Read, bus.LadOe, bus.LadOut, RegAddress, Data,
                      e.w, e.r, e.lad, e.addr, e.data);
      end
    end
    if (fin_req && !fin_ack) begin
      chk("sb_drained", 32'(rd), 32'(q.size()));
      fin_ack = 1'b1;
    end
  end

  task automatic push(input int c, input logic w, input logic r,
                      input logic [3:0] lad, input logic [4:0] a,
                      input logic [7:0] d);
    ev_t e;
    e = '{cyc: c, w: w, r: r, lad: lad, addr: a, data: d};
    q.push_back(e);
  endtask

  task automatic exp_write(input int t0, input logic [4:0] a,
                           input logic [7:0] d);
    int s;
    s = t0 + 10;
`ifdef LPC_SYNC_WAIT_EN
    push(s, 1, 0, 4'h5, a, d);
    push(s + 1, 0, 0, 4'h0, a, d);
`else
    push(s, 1, 0, 4'h0, a, d);
`endif
    push(s + 1 + SW, 0, 0, 4'hF, a, d);
  endtask

  task automatic exp_read(input int t0, input logic [4:0] a,
                          input logic [7:0] d);
    int s;
    s = t0 + 8;
`ifdef LPC_SYNC_WAIT_EN
    push(s, 0, 1, 4'h5, a, 8'h00);
    push(s + 1, 0, 0, 4'h0, a, 8'h00);
`else
    push(s, 0, 1, 4'h0, a, 8'h00);
`endif
    push(s + 1 + SW, 0, 0, d[3:0], a, 8'h00);
    push(s + 2 + SW, 0, 0, d[7:4], a, 8'h00);
    push(s + 3 + SW, 0, 0, 4'hF, a, 8'h00);
  endtask

  task automatic step(input logic f, input logic [3:0] l);
    bus.LFRAMEn = f;
    bus.LadIn   = l;
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic [3:0] ct, input logic [15:0] a,
                      input logic [7:0] d, input bit wr);
    step(1'b0, 4'h0);
    step(1'b1, ct);
    for (int i = 0; i < 4; i++) step(1'b1, a[15 - 4 * i -: 4]);
    if (wr) begin
      step(1'b1, d[3:0]);
      step(1'b1, d[7:4]);
    end
    repeat (10) step(1'b1, 4'hF);
  endtask

  task automatic reset_check();
    rc_req = rc_req + 1;
    for (int i = 0; i < 4 && rc_ack != rc_req; i++) begin
      @(negedge clk);
      #1;
    end
    if (rc_ack != rc_req) begin
      $display("FAIL rst_probe: monitor did not respond");
      $fatal(1);
    end
  endtask

  initial begin
    PciReset    = 1'b0;
    bus.LFRAMEn = 1'b1;
    bus.LadIn   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    @(posedge clk);
    #1;
    PciReset = 1'b1;
    repeat (2) step(1'b1, 4'hF);

    exp_write(cyc, 5'h0B, 8'h15);
    xact(IO_WR, 16'h080B, 8'h15, 1'b1);

    exp_read(cyc, 5'h03, 8'hA5);
    xact(IO_RD, 16'h0803, 8'h00, 1'b0);

    xact(IO_WR, 16'h090B, 8'h77, 1'b1);

    xact(4'h4, 16'h0800, 8'h00, 1'b0);
    exp_write(cyc, 5'h1F, 8'hC3);
    xact(IO_WR, 16'h081F, 8'hC3, 1'b1);

    step(1'b0, 4'h0);
    step(1'b1, IO_WR);
    step(1'b1, 4'h0);
    step(1'b1, 4'h8);
    exp_write(cyc, 5'h00, 8'h5A);
    xact(IO_WR, 16'h0800, 8'h5A, 1'b1);

    step(1'b0, 4'h0);
    step(1'b1, IO_RD);
    step(1'b1, 4'h0);
    step(1'b1, 4'h8);
    step(1'b1, 4'h0);
    step(1'b1, 4'h5);
    repeat (2) step(1'b1, 4'hF);
    #2;
    PciReset = 1'b0;
    reset_check();
    @(posedge clk);
    #1;
    PciReset = 1'b1;
    repeat (2) step(1'b1, 4'hF);

    exp_read(cyc, 5'h05, 8'h3C);
    xact(IO_RD, 16'h0805, 8'h00, 1'b0);

    repeat (4) step(1'b1, 4'hF);
    fin_req = 1'b1;
    for (int i = 0; i < 4 && !fin_ack; i++) begin
      @(negedge clk);
      #1;
    end
    if (!fin_ack) begin
      $display("FAIL sb_final: monitor did not respond");
      $fatal(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
